// File: rtl/median_row_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : median_row_serializer_if
// Description : Bundles the row-capture and pixel-stream signals of the
//               median row serializer.
//               slave  - serializer side (accepts rows, drives pixels)
//               master - environment side (drives rows, consumes pixels)
// Ports       : row_in/row_valid/row_ready  - parallel row handshake
//               pix_out/pix_valid/pix_ready - serial pixel handshake
//               pix_first/pix_last          - row boundary markers
//               rows_sent                   - wrapping count of sent rows
// Revision    : 1.0 - initial release
// ============================================================================
interface median_row_serializer_if #(
    parameter int SIZE  = 100,
    parameter int CNT_W = 16
);
    logic [SIZE-2:0][7:0] row_in;
    logic                 row_valid;
    logic                 row_ready;
    logic [7:0]           pix_out;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_first;
    logic                 pix_last;
    logic [CNT_W-1:0]     rows_sent;

    modport slave (
        input  row_in, row_valid, pix_ready,
        output row_ready, pix_out, pix_valid, pix_first, pix_last, rows_sent
    );

    modport master (
        output row_in, row_valid, pix_ready,
        input  row_ready, pix_out, pix_valid, pix_first, pix_last, rows_sent
    );
endinterface
`default_nettype wire

// File: rtl/median_row_serializer.sv
`default_nettype none
// ============================================================================
// Module      : median_row_serializer
// Description : Captures one filtered row (SIZE-2 valid 8-bit medians) in a
//               single cycle and streams it out one pixel per cycle over a
//               valid/ready interface with first/last markers and a wrapping
//               count of fully transmitted rows.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - median_row_serializer_if.slave (row in, pixels out)
// Options     : MEDIAN_BORDER_PAD_EN - when defined each row is padded to
//               SIZE beats by replicating the first and last medians.
// Revision    : 1.0 - initial release
// ============================================================================
module median_row_serializer #(
    parameter int SIZE  = 100,
    parameter int CNT_W = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    median_row_serializer_if.slave bus
);

    localparam int NVAL = SIZE - 2;
`ifdef MEDIAN_BORDER_PAD_EN
    localparam int NBEATS = SIZE;
`else
    localparam int NBEATS = SIZE - 2;
`endif
    localparam int               IDX_W    = $clog2(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] rows_sent_q;
    logic [7:0]       bank_q [NVAL];

    logic             valid_d;
    logic             last_beat_d;
    logic             accept_d;
    logic [IDX_W-1:0] sel_d;
    logic [7:0]       pix_sel_d;

    // The top entry of row_in is never driven by the filter.
    logic [7:0] unused_top_entry;
    assign unused_top_entry = bus.row_in[SIZE-2];

    assign valid_d     = (state_q == SEND);
    assign last_beat_d = (idx_q == LAST_IDX);

    // Second term lets the next row load on the final handshake so rows
    // follow each other with no idle cycle.
    assign bus.row_ready = (state_q == IDLE) ||
                           (valid_d && bus.pix_ready && last_beat_d);
    assign accept_d      = bus.row_valid && bus.row_ready;

    // Map beat index to holding-bank entry.
    always_comb begin
        sel_d = idx_q;
`ifdef MEDIAN_BORDER_PAD_EN
        // Beat 0 and the final beat replicate the edge medians; the
        // beats in between are shifted down by one.
        if (idx_q == '0) begin
            sel_d = '0;
        end else if (idx_q == LAST_IDX) begin
            sel_d = IDX_W'(NVAL - 1);
        end else begin
            sel_d = idx_q - IDX_W'(1);
        end
`endif
        pix_sel_d = 8'h00;
        for (int i = 0; i < NVAL; i++) begin
            if (sel_d == IDX_W'(i)) begin
                pix_sel_d = bank_q[i];
            end
        end
    end

    assign bus.pix_valid = valid_d;
    assign bus.pix_out   = valid_d ? pix_sel_d : 8'h00;
    assign bus.pix_first = valid_d && (idx_q == '0);
    assign bus.pix_last  = valid_d && last_beat_d;
    assign bus.rows_sent = rows_sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rows_sent_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (bus.pix_ready) begin
                        if (!last_beat_d) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else begin
                            rows_sent_q <= rows_sent_q + CNT_W'(1);
                            idx_q       <= '0;
                            // row_ready is high here, so row_valid alone
                            // means the next row is being accepted.
                            if (!bus.row_valid) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Holding bank carries no reset; its contents only matter after a load.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            for (int i = 0; i < NVAL; i++) begin
                bank_q[i] <= bus.row_in[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median_row_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_row_serializer
// Description : Self-checking bench for median_row_serializer (SIZE=6,
//               CNT_W=2). Directed scenarios followed by random traffic,
//               compared every cycle against a queue-based row model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_row_serializer;

    localparam int SIZE  = 6;
    localparam int CNT_W = 2;

    typedef logic [SIZE-2:0][7:0] row_t;
    typedef struct packed {
        logic [7:0] pix;
        logic       first;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median_row_serializer_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

    median_row_serializer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    int    sent_total = 0;
    logic  accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected pixel sequence of one row.
    task automatic push_row(input row_t row);
        int    vals[$];
        beat_t b;
        vals.delete();
`ifdef MEDIAN_BORDER_PAD_EN
        vals.push_back(int'(row[0]));
        for (int i = 0; i < SIZE - 2; i++) vals.push_back(int'(row[i]));
        vals.push_back(int'(row[SIZE-3]));
`else
        for (int i = 0; i < SIZE - 2; i++) vals.push_back(int'(row[i]));
`endif
        foreach (vals[k]) begin
            b.pix   = 8'(vals[k]);
            b.first = (k == 0);
            b.last  = (k == vals.size() - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: drive, check outputs before the edge, advance model.
    task automatic cycle(input logic r, input logic rv, input row_t row, input logic pr);
        logic  exp_ready;
        logic  busy;
        beat_t b;
        rst           = r;
        bus.row_valid = rv;
        bus.row_in    = row;
        bus.pix_ready = pr;
        #2;
        busy      = (exp_q.size() != 0);
        exp_ready = !busy || (exp_q.size() == 1 && pr);
        check("pix_valid", 32'(bus.pix_valid), 32'(busy));
        check("pix_out",   32'(bus.pix_out),   busy ? 32'(exp_q[0].pix)   : 32'd0);
        check("pix_first", 32'(bus.pix_first), busy ? 32'(exp_q[0].first) : 32'd0);
        check("pix_last",  32'(bus.pix_last),  busy ? 32'(exp_q[0].last)  : 32'd0);
        check("row_ready", 32'(bus.row_ready), 32'(exp_ready));
        check("rows_sent", 32'(bus.rows_sent), 32'(sent_total % (1 << CNT_W)));
        @(posedge clk);
        accepted = 1'b0;
        if (r) begin
            exp_q.delete();
            sent_total = 0;
        end else begin
            if (busy && pr) begin
                b = exp_q.pop_front();
                if (b.last) sent_total++;
            end
            if (exp_ready && rv) begin
                push_row(row);
                accepted = 1'b1;
            end
        end
        #1;
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < SIZE - 1; i++) r[i] = 8'($urandom);
        return r;
    endfunction

    function automatic row_t mk_row(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d); r[4] = 8'hEE;
        return r;
    endfunction

    initial begin
        row_t ra;
        row_t rb;
        row_t rz;
        int   n;
        rz            = '0;
        rst           = 1'b1;
        bus.row_valid = 1'b0;
        bus.row_in    = '0;
        bus.pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, rz, 1'b1);

        // Single row.
        ra = mk_row(10, 20, 30, 40);
        cycle(1'b0, 1'b1, ra, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, rand_row(), 1'b1);

        // Back-to-back: second row held until taken on the last handshake.
        rb = mk_row(1, 2, 3, 4);
        cycle(1'b0, 1'b1, ra, 1'b1);
        n = 0;
        do begin
            cycle(1'b0, 1'b1, rb, 1'b1);
            n++;
        end while (!accepted && n < 20);
        check("b2b_accept", 32'(accepted), 32'd1);
        repeat (8) cycle(1'b0, 1'b0, rz, 1'b1);

        // Backpressure for three cycles on the second beat.
        cycle(1'b0, 1'b1, ra, 1'b1);
        cycle(1'b0, 1'b0, rz, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, rz, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, rz, 1'b1);

        // Reset in the middle of a row, then a fresh row.
        cycle(1'b0, 1'b1, ra, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, rz, 1'b1);
        cycle(1'b1, 1'b0, rz, 1'b1);
        cycle(1'b0, 1'b1, mk_row(5, 6, 7, 8), 1'b1);
        repeat (8) cycle(1'b0, 1'b0, rz, 1'b1);

        // Counter wrap over five rows.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, rand_row(), 1'b1);
            repeat (SIZE + 1) cycle(1'b0, 1'b0, rand_row(), 1'b1);
        end

        // Random traffic with occasional resets and changing row_in.
        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  rand_row(), ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
